// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode, state and control-code definitions for the multi-cycle CPU control unit.
package cpu_ctrl_pkg;

    // Opcodes latched by the instruction register
    localparam logic [5:0] OpAdd   = 6'b000000;
    localparam logic [5:0] OpSub   = 6'b000001;
    localparam logic [5:0] OpAddiu = 6'b000010;
    localparam logic [5:0] OpAnd   = 6'b010000;
    localparam logic [5:0] OpAndi  = 6'b010001;
    localparam logic [5:0] OpOri   = 6'b010010;
    localparam logic [5:0] OpXori  = 6'b010011;
    localparam logic [5:0] OpSll   = 6'b011000;
    localparam logic [5:0] OpSlti  = 6'b100110;
    localparam logic [5:0] OpSw    = 6'b110000;
    localparam logic [5:0] OpLw    = 6'b110001;
    localparam logic [5:0] OpBeq   = 6'b110100;
    localparam logic [5:0] OpBne   = 6'b110101;
    localparam logic [5:0] OpBltz  = 6'b110110;
    localparam logic [5:0] OpJ     = 6'b111000;
    localparam logic [5:0] OpJr    = 6'b111001;
    localparam logic [5:0] OpJal   = 6'b111010;

    // Control FSM state encoding (visible on curState)
    typedef enum logic [2:0] {
        StIf    = 3'b000,
        StId    = 3'b001,
        StExeLs = 3'b010,
        StMem   = 3'b011,
        StWbLd  = 3'b100,
        StExeBr = 3'b101,
        StExeAl = 3'b110,
        StWbAl  = 3'b111
    } state_e;

    // ALUOp codes
    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluSll = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluAnd = 3'b100;
    localparam logic [2:0] AluSlt = 3'b101;
    localparam logic [2:0] AluXor = 3'b110;

    // PCSrc codes
    localparam logic [1:0] PcNext   = 2'b00;
    localparam logic [1:0] PcBranch = 2'b01;
    localparam logic [1:0] PcReg    = 2'b10;
    localparam logic [1:0] PcJump   = 2'b11;

    // RegDst codes
    localparam logic [1:0] RegDst31 = 2'b00;
    localparam logic [1:0] RegDstRt = 2'b01;
    localparam logic [1:0] RegDstRd = 2'b10;

    // One-hot instruction class; alu is register-register, imm_alu uses the immediate
    typedef struct packed {
        logic alu;
        logic imm_alu;
        logic branch;
        logic mem;
        logic jump;
        logic halt;
        logic nop;
    } op_class_t;

    // ALU operation for an ALU-class opcode
    function automatic logic [2:0] alu_op_of(input logic [5:0] op);
        case (op)
            OpSub:         alu_op_of = AluSub;
            OpAnd, OpAndi: alu_op_of = AluAnd;
            OpOri:         alu_op_of = AluOr;
            OpXori:        alu_op_of = AluXor;
            OpSll:         alu_op_of = AluSll;
            OpSlti:        alu_op_of = AluSlt;
            default:       alu_op_of = AluAdd;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_opclass_decode.sv
// Maps the latched opcode onto a one-hot instruction class.
module ctrl_opclass_decode
    import cpu_ctrl_pkg::*;
#(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic [5:0] opCode,
    output op_class_t  op_class
);

    // Halt is checked first so a remapped HALT_OP still wins over other classes
    always_comb begin
        op_class = '0;
        if (opCode == HALT_OP) begin
            op_class.halt = 1'b1;
        end else begin
            case (opCode)
                OpAdd, OpSub, OpAnd, OpSll:             op_class.alu     = 1'b1;
                OpAddiu, OpAndi, OpOri, OpXori, OpSlti: op_class.imm_alu = 1'b1;
                OpBeq, OpBne, OpBltz:                   op_class.branch  = 1'b1;
                OpSw, OpLw:                             op_class.mem     = 1'b1;
                OpJ, OpJr, OpJal:                       op_class.jump    = 1'b1;
                default:                                op_class.nop     = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Control FSM for the multi-cycle CPU: sequences IF/ID/EXE/MEM/WB and drives datapath controls.
module multicycle_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] opCode,
    input  logic       zero,
    input  logic       sign,
    output logic       IRWre,
    output logic       PCWre,
    output logic       InsMemRW,
    output logic       RegWre,
    output logic       mRD,
    output logic       mWR,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic       ExtSel,
    output logic       DBDataSrc,
    output logic       WrRegDSrc,
    output logic [1:0] RegDst,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUOp,
    output logic [2:0] curState
);

    state_e    state_q, state_d;
    op_class_t cls;
    logic      br_taken;
    logic      alu_ext;

    ctrl_opclass_decode #(
        .HALT_OP (HALT_OP)
    ) u_decode (
        .opCode   (opCode),
        .op_class (cls)
    );

    assign curState = state_q;
    assign alu_ext  = (opCode == OpAddiu) || (opCode == OpSlti);
    assign br_taken = ((opCode == OpBeq) && zero) || ((opCode == OpBne) && !zero) ||
                      ((opCode == OpBltz) && sign);

    // State register, the only storage in the control unit
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIf;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control outputs from (state, opCode, zero, sign)
    always_comb begin
        state_d   = state_q;
        IRWre     = 1'b0;
        PCWre     = 1'b0;
        InsMemRW  = 1'b0;
        RegWre    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        DBDataSrc = 1'b0;
        WrRegDSrc = 1'b0;
        RegDst    = RegDst31;
        PCSrc     = PcNext;
        ALUOp     = AluAdd;
        unique case (state_q)
            StIf: begin
                InsMemRW = 1'b1;
                IRWre    = 1'b1;
                state_d  = StId;
            end
            StId: begin
                if (cls.halt) begin
                    state_d = StId;
                end else if (cls.alu || cls.imm_alu) begin
                    state_d = StExeAl;
                end else if (cls.branch) begin
                    state_d = StExeBr;
                end else if (cls.mem) begin
                    state_d = StExeLs;
                end else if (cls.jump) begin
                    PCWre   = 1'b1;
                    PCSrc   = (opCode == OpJr) ? PcReg : PcJump;
                    RegWre  = (opCode == OpJal);
                    state_d = StIf;
                end else begin
                    PCWre   = 1'b1;
                    state_d = StIf;
                end
            end
            StExeAl: begin
                ALUOp   = alu_op_of(opCode);
                ALUSrcA = (opCode == OpSll);
                ALUSrcB = cls.imm_alu;
                ExtSel  = alu_ext;
                state_d = StWbAl;
            end
            StWbAl: begin
                ALUOp     = alu_op_of(opCode);
                ALUSrcA   = (opCode == OpSll);
                ALUSrcB   = cls.imm_alu;
                ExtSel    = alu_ext;
                RegWre    = 1'b1;
                WrRegDSrc = 1'b1;
                PCWre     = 1'b1;
                RegDst    = cls.alu ? RegDstRd : RegDstRt;
                state_d   = StIf;
            end
            StExeBr: begin
                ExtSel  = 1'b1;
                PCWre   = 1'b1;
                ALUOp   = (opCode == OpBltz) ? AluAdd : AluSub;
                PCSrc   = br_taken ? PcBranch : PcNext;
                state_d = StIf;
            end
            StExeLs: begin
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
                state_d = StMem;
            end
            StMem: begin
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
                if (opCode == OpLw) begin
                    mRD     = 1'b1;
                    state_d = StWbLd;
                end else begin
                    mWR     = (opCode == OpSw);
                    PCWre   = 1'b1;
                    state_d = StIf;
                end
            end
            StWbLd: begin
                mRD       = 1'b1;
                DBDataSrc = 1'b1;
                WrRegDSrc = 1'b1;
                RegDst    = RegDstRt;
                RegWre    = 1'b1;
                PCWre     = 1'b1;
                state_d   = StIf;
            end
        endcase
        // Reset blocks every write strobe so an aborted instruction leaves no trace
        if (!Reset) begin
            IRWre  = 1'b0;
            PCWre  = 1'b0;
            RegWre = 1'b0;
            mWR    = 1'b0;
            mRD    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: random and directed instructions against a per-cycle instruction model.
module tb_multicycle_control_unit;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic [5:0] opCode = 6'd0;
    logic       zero = 1'b0;
    logic       sign = 1'b0;
    logic       IRWre, PCWre, InsMemRW, RegWre, mRD, mWR;
    logic       ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc;
    logic [1:0] RegDst, PCSrc;
    logic [2:0] ALUOp, curState;

    int n_checks = 0;
    int n_fail = 0;

    multicycle_control_unit dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .opCode    (opCode),
        .zero      (zero),
        .sign      (sign),
        .IRWre     (IRWre),
        .PCWre     (PCWre),
        .InsMemRW  (InsMemRW),
        .RegWre    (RegWre),
        .mRD       (mRD),
        .mWR       (mWR),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ExtSel    (ExtSel),
        .DBDataSrc (DBDataSrc),
        .WrRegDSrc (WrRegDSrc),
        .RegDst    (RegDst),
        .PCSrc     (PCSrc),
        .ALUOp     (ALUOp),
        .curState  (curState)
    );

    always #5 CLK = ~CLK;

    // Observed control word: state, 11 single-bit controls, RegDst, PCSrc, ALUOp
    logic [20:0] obs;
    assign obs = {curState, IRWre, PCWre, InsMemRW, RegWre, mRD, mWR, ALUSrcA, ALUSrcB,
                  ExtSel, DBDataSrc, WrRegDSrc, RegDst, PCSrc, ALUOp};

    // Instruction classes of the reference model: 0 alu, 1 branch, 2 memory, 3 jump, 4 halt, 5 nop
    function automatic int op_cls(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
            6'b010010, 6'b010011, 6'b011000, 6'b100110: return 0;
            6'b110100, 6'b110101, 6'b110110:            return 1;
            6'b110000, 6'b110001:                       return 2;
            6'b111000, 6'b111001, 6'b111010:            return 3;
            6'b111111:                                  return 4;
            default:                                    return 5;
        endcase
    endfunction

    function automatic int n_cycles(input logic [5:0] op);
        case (op_cls(op))
            0:       return 4;
            1:       return 3;
            2:       return (op == 6'b110001) ? 5 : 4;
            default: return 2;
        endcase
    endfunction

    // Expected control word in cycle k (0 = fetch) of instruction op, given this cycle's flags
    function automatic logic [20:0] exp_vec(input logic [5:0] op, input int k,
                                            input logic z, input logic s);
        logic [2:0] st, aop;
        logic irw, pcw, imr, rw, rd, wr, sa, sb, ex, dbs, wrs;
        logic [1:0] rdst, pcs;
        int c;
        c = op_cls(op);
        {st, aop, irw, pcw, imr, rw, rd, wr, sa, sb, ex, dbs, wrs, rdst, pcs} = '0;
        if (k == 0) begin
            irw = 1; imr = 1;
        end else if (k == 1) begin
            st = 3'd1;
            if (c == 3) begin
                pcw = 1;
                pcs = (op == 6'b111001) ? 2'd2 : 2'd3;
                rw  = (op == 6'b111010);
            end else if (c == 5) begin
                pcw = 1;
            end
        end else if (c == 0) begin
            st = (k == 2) ? 3'd6 : 3'd7;
            case (op)
                6'b000001:           aop = 3'd1;
                6'b010000, 6'b010001: aop = 3'd4;
                6'b010010:           aop = 3'd3;
                6'b010011:           aop = 3'd6;
                6'b011000:           aop = 3'd2;
                6'b100110:           aop = 3'd5;
                default:             aop = 3'd0;
            endcase
            sa = (op == 6'b011000);
            sb = (op inside {6'b000010, 6'b010001, 6'b010010, 6'b010011, 6'b100110});
            ex = (op inside {6'b000010, 6'b100110});
            if (k == 3) begin
                rw = 1; wrs = 1; pcw = 1;
                rdst = (op inside {6'b000000, 6'b000001, 6'b010000, 6'b011000}) ? 2'd2 : 2'd1;
            end
        end else if (c == 1) begin
            st = 3'd5; ex = 1; pcw = 1;
            aop = (op == 6'b110110) ? 3'd0 : 3'd1;
            if ((op == 6'b110100 && z) || (op == 6'b110101 && !z) || (op == 6'b110110 && s))
                pcs = 2'd1;
        end else if (c == 2) begin
            if (k == 2) begin
                st = 3'd2; sb = 1; ex = 1;
            end else if (k == 3) begin
                st = 3'd3; sb = 1; ex = 1;
                if (op == 6'b110001) rd = 1;
                else begin wr = 1; pcw = 1; end
            end else begin
                st = 3'd4; rd = 1; dbs = 1; wrs = 1; rdst = 2'd1; rw = 1; pcw = 1;
            end
        end
        return {st, irw, pcw, imr, rw, rd, wr, sa, sb, ex, dbs, wrs, rdst, pcs, aop};
    endfunction

    task automatic drive(input logic [5:0] op, input logic z, input logic s);
        opCode = op;
        zero   = z;
        sign   = s;
    endtask

    task automatic test_reset();
        logic [20:0] e;
        #1 Reset = 1'b0;
        #1;
        n_checks++;
        if ({curState, IRWre, PCWre, RegWre, mRD, mWR} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %b, expected 00000000",
                     {curState, IRWre, PCWre, RegWre, mRD, mWR});
        end
        @(posedge CLK); #1;
        Reset = 1'b1;
        // Run add into EXE_AL, then abort it with reset
        for (int k = 0; k < 3; k++) begin
            drive((k == 0) ? 6'($urandom) : 6'b000000, 1'($urandom), 1'($urandom));
            @(negedge CLK);
            e = exp_vec(6'b000000, k, zero, sign);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_pre cycle %0d: got %b, expected %b", k, obs, e);
            end
            if (k < 2) begin @(posedge CLK); #1; end
        end
        #2 Reset = 1'b0;
        #1;
        n_checks++;
        if ({curState, IRWre, PCWre, RegWre, mRD, mWR} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_abort: got %b, expected 00000000",
                     {curState, IRWre, PCWre, RegWre, mRD, mWR});
        end
        @(posedge CLK); #1;
        n_checks++;
        if ({curState, RegWre, PCWre} !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got %b, expected 00000", {curState, RegWre, PCWre});
        end
        Reset = 1'b1;
        #1;
        n_checks++;
        if ({curState, IRWre, RegWre} !== 5'b00010) begin
            n_fail++;
            $display("FAIL reset_release: got %b, expected 00010", {curState, IRWre, RegWre});
        end
    endtask

    // Directed instruction with random flags; name identifies the scenario in FAIL lines
    task automatic test_instr(input string name, input logic [5:0] op,
                              input logic z, input logic s);
        logic [20:0] e;
        int n;
        n = n_cycles(op);
        for (int k = 0; k < n; k++) begin
            if (k == 0) drive(6'($urandom), 1'($urandom), 1'($urandom));
            else if (k == 2) drive(op, z, s);
            else drive(op, 1'($urandom), 1'($urandom));
            @(negedge CLK);
            e = exp_vec(op, k, zero, sign);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %b, expected %b", name, k, obs, e);
            end
            @(posedge CLK); #1;
        end
        n_checks++;
        if (curState !== 3'd0) begin
            n_fail++;
            $display("FAIL %s_length: state after %0d cycles got %0d, expected 0",
                     name, n, curState);
        end
    endtask

    task automatic test_halt();
        logic [20:0] e;
        drive(6'($urandom), 1'b0, 1'b0);
        @(negedge CLK);
        e = exp_vec(6'b111111, 0, zero, sign);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL halt_fetch: got %b, expected %b", obs, e);
        end
        @(posedge CLK); #1;
        for (int k = 0; k < 20; k++) begin
            drive(6'b111111, 1'($urandom), 1'($urandom));
            @(negedge CLK);
            e = exp_vec(6'b111111, 1, zero, sign);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL halt cycle %0d: got %b, expected %b", k, obs, e);
            end
            @(posedge CLK); #1;
        end
        Reset = 1'b0;
        #1;
        n_checks++;
        if (curState !== 3'd0) begin
            n_fail++;
            $display("FAIL halt_reset: got %0d, expected 0", curState);
        end
        @(posedge CLK); #1;
        Reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [5:0] pool [17];
        logic [5:0] op;
        logic [20:0] e;
        int n;
        pool = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010,
                 6'b010011, 6'b011000, 6'b100110, 6'b110000, 6'b110001, 6'b110100,
                 6'b110101, 6'b110110, 6'b111000, 6'b111001, 6'b111010};
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 4) == 0) op = 6'($urandom);
            else op = pool[$urandom_range(0, 16)];
            if (op == 6'b111111) op = 6'b101010;
            n = n_cycles(op);
            for (int k = 0; k < n; k++) begin
                drive((k == 0) ? 6'($urandom) : op, 1'($urandom), 1'($urandom));
                @(negedge CLK);
                e = exp_vec(op, k, zero, sign);
                n_checks++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL random op %b cycle %0d: got %b, expected %b", op, k, obs, e);
                end
                @(posedge CLK); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_instr("add", 6'b000000, 1'b0, 1'b0);
        test_instr("lw", 6'b110001, 1'b0, 1'b0);
        test_instr("sw", 6'b110000, 1'b0, 1'b0);
        test_instr("beq_taken", 6'b110100, 1'b1, 1'b0);
        test_instr("beq_not_taken", 6'b110100, 1'b0, 1'b1);
        test_instr("bne_zero", 6'b110101, 1'b1, 1'b0);
        test_instr("bltz_taken", 6'b110110, 1'b0, 1'b1);
        test_instr("jal", 6'b111010, 1'b0, 1'b0);
        test_instr("jr", 6'b111001, 1'b0, 1'b0);
        test_instr("slti", 6'b100110, 1'b0, 1'b0);
        test_instr("sll", 6'b011000, 1'b0, 1'b0);
        test_instr("nop", 6'b101010, 1'b0, 1'b0);
        test_halt();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no end, expected end");
        $fatal(1, "timeout");
    end

endmodule
